// File: rtl/paddle_cmd_writer.sv
// Paddle-position command initiator: debounces player buttons, integrates them once
// per video frame and writes changed bar positions to the display over CMD_EN/CMD_DATA.
module paddle_cmd_writer #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned STEP            = 4,
  parameter int unsigned Y_MIN           = 0,
  parameter int unsigned Y_MAX           = 420,
  parameter int unsigned Y_INIT          = 210,
  parameter int unsigned STROBE_LEN      = 2
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        BTN_UP1,
  input  logic        BTN_DN1,
  input  logic        BTN_UP2,
  input  logic        BTN_DN2,
  input  logic        VGA_VS_I,
  output logic        CMD_EN,
  output logic [31:0] CMD_DATA,
  output logic        BUSY
);

  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SCNT_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CALC   = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] STROBE = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] NEXT   = 3'd5;

  // Button bit order: [0]=UP1 [1]=DN1 [2]=UP2 [3]=DN2
  logic [3:0]       btn_raw, btn_s1, btn_s2, btn_db;
  logic [CNT_W-1:0] db_cnt [4];
  logic             vs_s1, vs_s2, vs_d, tick;

  logic [2:0]        state;
  logic [SCNT_W-1:0] scnt;
  logic [9:0]        y1, y2, y1_nx, y2_nx;
  logic              dirty1, dirty2, d1_nx, d2_nx;
  logic              sel, frame_pending, force_both;

  assign btn_raw = {BTN_DN2, BTN_UP2, BTN_DN1, BTN_UP1};

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      vs_s1  <= 1'b1;
      vs_s2  <= 1'b1;
      vs_d   <= 1'b1;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      vs_s1  <= VGA_VS_I;
      vs_s2  <= vs_s1;
      vs_d   <= vs_s2;
    end
  end

  assign tick = vs_d & ~vs_s2;

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      btn_db <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (btn_s2[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db[i] <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lower bound is tested before subtracting so the unsigned Y never wraps.
  function automatic logic [9:0] next_y(input logic [9:0] y, input logic up, input logic dn);
    logic [10:0] sum;
    sum    = {1'b0, y} + 11'(STEP);
    next_y = y;
    if (up && !dn)
      next_y = (y < 10'(Y_MIN + STEP)) ? 10'(Y_MIN) : y - 10'(STEP);
    else if (dn && !up)
      next_y = (sum > 11'(Y_MAX)) ? 10'(Y_MAX) : sum[9:0];
  endfunction

  always_comb begin
    y1_nx = next_y(y1, btn_db[0], btn_db[1]);
    y2_nx = next_y(y2, btn_db[2], btn_db[3]);
    d1_nx = (y1_nx != y1) | force_both;
    d2_nx = (y2_nx != y2) | force_both;
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state         <= IDLE;
      scnt          <= '0;
      y1            <= 10'(Y_INIT);
      y2            <= 10'(Y_INIT);
      dirty1        <= 1'b0;
      dirty2        <= 1'b0;
      sel           <= 1'b0;
      frame_pending <= 1'b0;
      force_both    <= 1'b1;
      CMD_EN        <= 1'b0;
      CMD_DATA      <= '0;
    end else begin
      if (tick && state != IDLE) frame_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (tick || frame_pending) begin
            frame_pending <= 1'b0;
            state         <= CALC;
          end
        end
        CALC: begin
          y1     <= y1_nx;
          y2     <= y2_nx;
          dirty1 <= d1_nx;
          dirty2 <= d2_nx;
          // Data is loaded on entry to SETUP so it leads CMD_EN by a full cycle.
          if (d1_nx) begin
            sel      <= 1'b0;
            CMD_DATA <= {21'd0, 1'b0, y1_nx};
            state    <= SETUP;
          end else if (d2_nx) begin
            sel      <= 1'b1;
            CMD_DATA <= {21'd0, 1'b1, y2_nx};
            state    <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          CMD_EN <= 1'b1;
          scnt   <= '0;
          state  <= STROBE;
        end
        STROBE: begin
          if (scnt == SCNT_W'(STROBE_LEN - 1)) begin
            CMD_EN <= 1'b0;
            state  <= HOLD;
          end else begin
            scnt <= scnt + SCNT_W'(1);
          end
        end
        HOLD: begin
          if (sel) dirty2 <= 1'b0;
          else     dirty1 <= 1'b0;
          state <= NEXT;
        end
        NEXT: begin
          if (dirty2) begin
            sel      <= 1'b1;
            CMD_DATA <= {21'd0, 1'b1, y2};
            state    <= SETUP;
          end else begin
            force_both <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/paddle_cmd_writer.md
Name: paddle_cmd_writer

Overview:
- Initiator side of the paddle-position command interface consumed by the VGA pong display.
- Debounces four player buttons and integrates them into two paddle Y positions, once per video frame.
- Issues write commands (strobe plus 32-bit data word, bit 10 selecting the bar) so the display latches new positions between frames.
- Sits between the board buttons, the VGA vertical-sync output and the display's command inputs.

Parameters:
DEBOUNCE_CYCLES, 65536, CLK cycles an input must stay stable before its debounced value changes (use 4 in simulation)
STEP, 4, pixels moved per frame while a direction button is held
Y_MIN, 0, lowest legal paddle Y
Y_MAX, 420, highest legal paddle Y (480 minus bar height)
Y_INIT, 210, paddle Y after reset
STROBE_LEN, 2, CLK cycles CMD_EN is held high per command

Ports:
CLK  input  1  board clock; all logic on the rising edge
RST_BTN  input  1  reset, asynchronous, active-low
BTN_UP1  input  1  raw button, bar 1 up, active-high, asynchronous
BTN_DN1  input  1  raw button, bar 1 down
BTN_UP2  input  1  raw button, bar 2 up
BTN_DN2  input  1  raw button, bar 2 down
VGA_VS_I  input  1  vertical sync from the VGA timing block, active-low pulse
CMD_EN  output  1  command strobe; the receiver latches CMD_DATA on its rising edge
CMD_DATA  output  32  [9:0] Y, [10] bar select (0 = bar 1, 1 = bar 2), [31:11] always 0
BUSY  output  1  high while a command sequence is in progress

Behaviour:
- Reset (RST_BTN low, asynchronous):
  - CMD_EN=0, CMD_DATA=0, BUSY=0.
  - Both positions = Y_INIT; debounced button values = 0; debounce counters = 0.
  - frame_pending=0, force_both=1. Reset mid-sequence aborts the sequence immediately.
- Input sync: every button and VGA_VS_I passes through 2 flip-flops before any use.
- Debounce, per button:
  - The counter clears whenever the synced value equals the debounced value.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1, the debounced value takes the synced value and the counter clears.
- Frame tick: a one-cycle pulse on the falling edge of the synced VGA_VS_I.
- Position update, in the cycle after a tick is accepted (IDLE with a tick or frame_pending):
  - Up only: Y = max(Y-STEP, Y_MIN), computed without unsigned underflow (if Y < Y_MIN+STEP then Y_MIN).
  - Down only: Y = min(Y+STEP, Y_MAX).
  - Both buttons or neither: no change.
  - Each bar is marked dirty if its Y changed, or if force_both=1.
- FSM states: IDLE, CALC, SETUP, STROBE, HOLD, NEXT.
  - IDLE: on a tick or frame_pending, clear frame_pending and go to CALC.
  - CALC: update positions and dirty flags. If neither bar is dirty, return to IDLE; otherwise select the first dirty bar (bar 1 first) and go to SETUP.
  - SETUP (1 cycle): CMD_DATA = {21'b0, sel, Y_sel}; CMD_EN=0.
  - STROBE (STROBE_LEN cycles): CMD_EN=1; CMD_DATA held.
  - HOLD (1 cycle): CMD_EN=0; CMD_DATA still held; clear that bar's dirty flag.
  - NEXT: if bar 2 is still dirty, select it and go to SETUP; otherwise clear force_both and go to IDLE.
- CMD_DATA is stable at least 1 cycle before, during, and 1 cycle after each CMD_EN high period. It keeps its last value in IDLE.
- BUSY is high in every state except IDLE.
- A tick arriving while not in IDLE sets frame_pending. Multiple ticks collapse into one pending update; none are lost beyond that.
- Debouncing continues during a sequence. Positions sample the debounced values only in CALC.
- Latency: tick to first CMD_EN rise = 3 cycles (IDLE→CALC→SETUP→STROBE), excluding the 2-cycle sync delay.

Test Plan:
- Reset released, no buttons, first VS tick -> two commands: CMD_DATA=0x0000_00D2 then 0x0000_04D2, each with CMD_EN high 2 cycles. The next tick sends no command; BUSY stays 0.
- BTN_DN1 held past debounce, 3 ticks -> bar 1 commands with Y=214, 218, 222 (0x0D6, 0x0DA, 0x0DE); no bar 2 commands.
- Bar 2 set near the top (Y=2) with BTN_UP2 held -> next command 0x0000_0400 (Y clamped to 0); further ticks send nothing.
- Bar 1 at 418 with BTN_DN1 held -> command Y=420, then no commands; both UP1 and DN1 held -> no change.
- BTN_UP1 glitch of 3 cycles with DEBOUNCE_CYCLES=4 -> debounced value unchanged, no command.
- Second VS tick during STROBE of a dual-bar update -> frame_pending set, and a further update starts 1 cycle after returning to IDLE.
- Reset asserted during STROBE -> CMD_EN and BUSY go 0 asynchronously; after release, the first tick re-sends both bars at Y_INIT.
